// File: rtl/tile_harness_ctrl.sv
// Host-to-tile command issuer with a first-word-fall-through result FIFO.
// Optional watchdog: define TILE_HARNESS_TIMEOUT_EN.
module tile_harness_ctrl #(
  parameter int REG_WIDTH      = 32,
  parameter int CSR_IN_WIDTH   = 16,
  parameter int CSR_OUT_WIDTH  = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     host_wr,
  input  logic [CSR_IN_WIDTH-1:0]  host_csr,
  input  logic [REG_WIDTH-1:0]     host_a,
  input  logic [REG_WIDTH-1:0]     host_b,
  output logic                     host_ready,
  output logic                     res_valid,
  output logic [CSR_OUT_WIDTH-1:0] res_csr,
  output logic [REG_WIDTH-1:0]     res_c,
  input  logic                     res_rd,
  input  logic                     clr_flags,
  output logic                     ovf_flag,
  output logic                     timeout_flag,
  output logic                     harness_en,
  output logic [CSR_IN_WIDTH-1:0]  csr_in,
  output logic [REG_WIDTH-1:0]     data_reg_a,
  output logic [REG_WIDTH-1:0]     data_reg_b,
  input  logic                     csr_in_re,
  input  logic [CSR_OUT_WIDTH-1:0] csr_out,
  input  logic [REG_WIDTH-1:0]     data_reg_c,
  input  logic                     csr_out_we
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = CSR_OUT_WIDTH + REG_WIDTH;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]              st_q, st_d;
  logic [CSR_IN_WIDTH-1:0] csr_q, csr_d;
  logic [REG_WIDTH-1:0]    a_q, a_d;
  logic [REG_WIDTH-1:0]    b_q, b_d;
  logic                    en_q, en_d;
  logic                    ovf_q;

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [PW:0]   cnt_q;
  logic          full, empty, pop, push, ovf_set, to_set;

  assign full    = (cnt_q == DEPTH_C);
  assign empty   = (cnt_q == '0);
  assign pop     = res_rd && !empty;
  assign push    = csr_out_we && (!full || pop);
  assign ovf_set = csr_out_we && full && !pop;

  assign host_ready = (st_q == S_IDLE) && !full;
  assign res_valid  = !empty;
  assign {res_csr, res_c} = empty ? '0 : mem_q[rp_q];
  assign harness_en = en_q;
  assign csr_in     = csr_q;
  assign data_reg_a = a_q;
  assign data_reg_b = b_q;
  assign ovf_flag   = ovf_q;

`ifdef TILE_HARNESS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmr_q, tmr_d;
  logic          to_q;
  assign timeout_flag = to_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_flag   = 1'b0;
`endif

  always_comb begin
    st_d   = st_q;
    csr_d  = csr_q;
    a_d    = a_q;
    b_d    = b_q;
    en_d   = en_q;
    to_set = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (host_wr && host_ready) begin
          csr_d = host_csr;
          a_d   = host_a;
          b_d   = host_b;
          en_d  = 1'b1;
          st_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (csr_in_re) begin
          csr_d = '0;
          a_d   = '0;
          b_d   = '0;
          if (csr_out_we) begin
            en_d = 1'b0;
            st_d = S_IDLE;
          end else begin
            st_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (csr_out_we) begin
          en_d = 1'b0;
          st_d = S_IDLE;
        end
      end
      default: begin
        en_d = 1'b0;
        st_d = S_IDLE;
      end
    endcase
`ifdef TILE_HARNESS_TIMEOUT_EN
    // Completion on the expiry cycle wins over the watchdog
    tmr_d = tmr_q;
    if (st_q == S_IDLE) begin
      tmr_d = '0;
    end else if (st_d != S_IDLE) begin
      if (tmr_q == TLAST) begin
        csr_d  = '0;
        a_d    = '0;
        b_d    = '0;
        en_d   = 1'b0;
        st_d   = S_IDLE;
        to_set = 1'b1;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      st_q  <= S_IDLE;
      csr_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      en_q  <= 1'b0;
      ovf_q <= 1'b0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      csr_q <= csr_d;
      a_q   <= a_d;
      b_q   <= b_d;
      en_q  <= en_d;
      if (ovf_set) ovf_q <= 1'b1;
      else if (clr_flags) ovf_q <= 1'b0;
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (arst_n && push) mem_q[wp_q] <= {csr_out, data_reg_c};
  end

`ifdef TILE_HARNESS_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      tmr_q <= '0;
      to_q  <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      if (to_set) to_q <= 1'b1;
      else if (clr_flags) to_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_tile_harness_ctrl.sv
// Bench for tile_harness_ctrl: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_tile_harness_ctrl;
  localparam int RW = 32;
  localparam int CIW = 16;
  localparam int COW = 16;
  localparam int FD = 4;
`ifdef TILE_HARNESS_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1023;
`endif
  localparam int VW = 3 + COW + RW + 3 + CIW + 2*RW;

  logic clk = 1'b0;
  logic arst_n, host_wr, res_rd, clr_flags, csr_in_re, csr_out_we;
  logic [CIW-1:0] host_csr, csr_in;
  logic [RW-1:0] host_a, host_b, res_c, data_reg_a, data_reg_b, data_reg_c;
  logic [COW-1:0] res_csr, csr_out;
  logic host_ready, res_valid, ovf_flag, timeout_flag, harness_en;

  int n_run = 0;
  int n_fail = 0;

  tile_harness_ctrl #(
    .REG_WIDTH(RW), .CSR_IN_WIDTH(CIW), .CSR_OUT_WIDTH(COW),
    .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .arst_n(arst_n), .host_wr(host_wr),
    .host_csr(host_csr), .host_a(host_a), .host_b(host_b),
    .host_ready(host_ready), .res_valid(res_valid),
    .res_csr(res_csr), .res_c(res_c), .res_rd(res_rd),
    .clr_flags(clr_flags), .ovf_flag(ovf_flag),
    .timeout_flag(timeout_flag), .harness_en(harness_en),
    .csr_in(csr_in), .data_reg_a(data_reg_a),
    .data_reg_b(data_reg_b), .csr_in_re(csr_in_re),
    .csr_out(csr_out), .data_reg_c(data_reg_c),
    .csr_out_we(csr_out_we)
  );

  always #5 clk = ~clk;

  // model: ph 0 = free, 1 = command presented, 2 = awaiting response
  int ph;
  int age;
  logic [COW+RW-1:0] q[$];
  logic [CIW-1:0] m_csr;
  logic [RW-1:0] m_a, m_b;
  logic m_ovf, m_to;

  logic [VW-1:0] dut_vec;
  assign dut_vec = {host_ready, res_valid, res_csr, res_c, ovf_flag,
                    timeout_flag, harness_en, csr_in, data_reg_a, data_reg_b};

  function automatic logic [VW-1:0] exp_vec();
    logic [COW+RW-1:0] head;
    head = (q.size() > 0) ? q[0] : '0;
    return {(ph == 0) && (q.size() < FD), q.size() > 0, head, m_ovf,
            m_to, ph != 0, m_csr, m_a, m_b};
  endfunction

  task automatic model_edge();
    bit full, rdy, pop, ovs, tos;
    int nph;
    if (!arst_n) begin
      ph = 0; age = 0; q.delete();
      m_csr = '0; m_a = '0; m_b = '0; m_ovf = 0; m_to = 0;
      return;
    end
    full = (q.size() == FD);
    rdy = (ph == 0) && !full;
    pop = res_rd && (q.size() > 0);
    ovs = 0; tos = 0; nph = ph;
    if (pop) void'(q.pop_front());
    if (csr_out_we) begin
      if (!full || pop) q.push_back({csr_out, data_reg_c});
      else ovs = 1;
    end
    case (ph)
      0: if (host_wr && rdy) begin
        m_csr = host_csr; m_a = host_a; m_b = host_b; nph = 1; age = 0;
      end
      1: if (csr_in_re) begin
        m_csr = '0; m_a = '0; m_b = '0;
        nph = csr_out_we ? 0 : 2;
      end
      default: if (csr_out_we) nph = 0;
    endcase
`ifdef TILE_HARNESS_TIMEOUT_EN
    if (ph != 0 && nph != 0) begin
      age++;
      if (age >= TO) begin
        nph = 0; m_csr = '0; m_a = '0; m_b = '0; tos = 1;
      end
    end
`endif
    if (ovs) m_ovf = 1; else if (clr_flags) m_ovf = 0;
    if (tos) m_to = 1; else if (clr_flags) m_to = 0;
    ph = nph;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    host_wr = 0; res_rd = 0; clr_flags = 0;
    csr_in_re = 0; csr_out_we = 0;
  endtask

  task automatic test_reset();
    arst_n = 0; idle_in();
    tick(); tick();
    arst_n = 1;
    n_run++;
    if (dut_vec !== exp_vec() || host_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_basic();
    host_wr = 1; host_csr = 16'h0001; host_a = 5; host_b = 7;
    tick();
    host_wr = 0;
    n_run++;
    if ({csr_in, data_reg_a, data_reg_b, harness_en, host_ready} !==
        {16'h0001, 32'd5, 32'd7, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_issue got %h/%0d/%0d en=%b rdy=%b exp 0001/5/7 en=1 rdy=0",
               csr_in, data_reg_a, data_reg_b, harness_en, host_ready);
    end
    tick(); tick();
    csr_in_re = 1;
    tick();
    csr_in_re = 0;
    n_run++;
    if (csr_in !== 16'h0 || harness_en !== 1'b1 || dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL basic_after_re got csr_in=%h en=%b exp 0000 en=1", csr_in, harness_en);
    end
    tick();
    csr_out_we = 1; csr_out = 16'h8000; data_reg_c = 12;
    tick();
    csr_out_we = 0;
    n_run++;
    if ({res_valid, res_csr, res_c, host_ready, harness_en} !==
        {1'b1, 16'h8000, 32'd12, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_resp got v=%b %h/%0d rdy=%b en=%b exp v=1 8000/12 rdy=1 en=0",
               res_valid, res_csr, res_c, host_ready, harness_en);
    end
    res_rd = 1;
    tick();
    res_rd = 0;
    n_run++;
    if (res_valid !== 1'b0 || dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL basic_pop got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_same_cycle();
    host_wr = 1; host_csr = 16'h00A5; host_a = 32'h11; host_b = 32'h22;
    tick();
    host_wr = 0;
    csr_in_re = 1; csr_out_we = 1; csr_out = 16'h4321; data_reg_c = 32'h99;
    tick();
    idle_in();
    n_run++;
    if ({harness_en, host_ready, res_valid, res_csr, csr_in} !==
        {1'b0, 1'b1, 1'b1, 16'h4321, 16'h0} || dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL same_cycle got %h exp %h", dut_vec, exp_vec());
    end
    res_rd = 1;
    tick();
    res_rd = 0;
    n_run++;
    if (res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_one_entry got valid=%b exp 0", res_valid);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      csr_out_we = 1; csr_out = 16'h0100 + 16'(i); data_reg_c = $urandom;
      tick();
    end
    csr_out_we = 0;
    n_run++;
    if ({ovf_flag, host_ready, res_csr} !== {1'b1, 1'b0, 16'h0100} ||
        dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL ovf_full got %h exp %h", dut_vec, exp_vec());
    end
    res_rd = 1;
    tick();
    res_rd = 0;
    n_run++;
    if ({host_ready, res_csr, ovf_flag} !== {1'b1, 16'h0101, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_pop got rdy=%b head=%h ovf=%b exp 1/0101/1",
               host_ready, res_csr, ovf_flag);
    end
    clr_flags = 1;
    tick();
    clr_flags = 0;
    n_run++;
    if (ovf_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clr got %b exp 0", ovf_flag);
    end
    for (int i = 1; i < 4; i++) begin
      n_run++;
      if (res_csr !== 16'h0100 + 16'(i) || res_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL ovf_order got %h exp %h", res_csr, 16'h0100 + 16'(i));
      end
      res_rd = 1;
      tick();
      res_rd = 0;
    end
  endtask

  task automatic test_full_pushpop();
    logic [COW-1:0] want [4];
    for (int i = 0; i < 4; i++) begin
      csr_out_we = 1; csr_out = 16'h0200 + 16'(i); data_reg_c = $urandom;
      tick();
    end
    csr_out_we = 1; res_rd = 1; csr_out = 16'h02AA; data_reg_c = 32'hAA;
    tick();
    idle_in();
    n_run++;
    if ({ovf_flag, res_csr, host_ready} !== {1'b0, 16'h0201, 1'b0} ||
        dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL pushpop got %h exp %h", dut_vec, exp_vec());
    end
    want[0] = 16'h0201; want[1] = 16'h0202; want[2] = 16'h0203; want[3] = 16'h02AA;
    for (int i = 0; i < 4; i++) begin
      n_run++;
      if (res_csr !== want[i]) begin
        n_fail++;
        $display("FAIL pushpop_order got %h exp %h", res_csr, want[i]);
      end
      res_rd = 1;
      tick();
      res_rd = 0;
    end
  endtask

  task automatic test_reset_mid();
    host_wr = 1; host_csr = 16'h7777; host_a = 1; host_b = 2;
    tick();
    host_wr = 0; csr_in_re = 1;
    tick();
    csr_in_re = 0;
    csr_out_we = 1; csr_out = 16'hDEAD; data_reg_c = 3;
    arst_n = 0;
    tick();
    arst_n = 1; csr_out_we = 0;
    n_run++;
    if ({host_ready, res_valid, harness_en, csr_in} !== {1'b1, 1'b0, 1'b0, 16'h0} ||
        dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_mid got %h exp %h", dut_vec, exp_vec());
    end
    csr_out_we = 1; csr_out = 16'hBEEF; data_reg_c = 4;
    tick();
    csr_out_we = 0;
    n_run++;
    if ({res_valid, res_csr, res_c, host_ready} !== {1'b1, 16'hBEEF, 32'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_mid_queue got %h exp %h", dut_vec, exp_vec());
    end
    res_rd = 1;
    tick();
    res_rd = 0;
  endtask

  task automatic test_timeout();
    host_wr = 1; host_csr = 16'h0F0F; host_a = 9; host_b = 10;
    tick();
    host_wr = 0;
`ifdef TILE_HARNESS_TIMEOUT_EN
    repeat (TO - 1) tick();
    n_run++;
    if (timeout_flag !== 1'b0 || harness_en !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_early got to=%b en=%b exp 0/1", timeout_flag, harness_en);
    end
    tick();
    n_run++;
    if ({timeout_flag, csr_in, host_ready, harness_en} !== {1'b1, 16'h0, 1'b1, 1'b0} ||
        dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL timeout_fire got %h exp %h", dut_vec, exp_vec());
    end
    csr_out_we = 1; csr_out = 16'h1A7E; data_reg_c = 5;
    tick();
    csr_out_we = 0;
    n_run++;
    if (res_valid !== 1'b1 || res_csr !== 16'h1A7E) begin
      n_fail++;
      $display("FAIL timeout_late got v=%b %h exp 1/1a7e", res_valid, res_csr);
    end
    res_rd = 1; clr_flags = 1;
    tick();
    idle_in();
`else
    repeat (20) tick();
    n_run++;
    if ({timeout_flag, harness_en, csr_in} !== {1'b0, 1'b1, 16'h0F0F}) begin
      n_fail++;
      $display("FAIL no_timeout got to=%b en=%b csr=%h exp 0/1/0f0f",
               timeout_flag, harness_en, csr_in);
    end
    csr_in_re = 1; csr_out_we = 1; csr_out = 1; data_reg_c = 1;
    tick();
    idle_in();
    res_rd = 1;
    tick();
    res_rd = 0;
`endif
    n_run++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL timeout_end got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      arst_n = ($urandom_range(0, 79) != 0);
      host_wr = $urandom_range(0, 1);
      host_csr = $urandom; host_a = $urandom; host_b = $urandom;
      csr_in_re = ($urandom_range(0, 2) == 0);
      csr_out_we = ($urandom_range(0, 3) == 0);
      csr_out = $urandom; data_reg_c = $urandom;
      res_rd = ($urandom_range(0, 3) == 0);
      clr_flags = ($urandom_range(0, 9) == 0);
      tick();
      n_run++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL random[%0d] got %h exp %h", i, dut_vec, exp_vec());
      end
    end
    arst_n = 1; idle_in();
  endtask

  initial begin
    arst_n = 0; idle_in();
    host_csr = '0; host_a = '0; host_b = '0;
    csr_out = '0; data_reg_c = '0;
    ph = 0; age = 0; m_csr = '0; m_a = '0; m_b = '0; m_ovf = 0; m_to = 0;
    test_reset();
    test_basic();
    test_same_cycle();
    test_overflow();
    test_full_pushpop();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/tile_harness_ctrl.md
# tile_harness_ctrl

Harness-side driver for a user tile's CSR/data-register interface: issues commands to the tile and collects its responses. Takes one command at a time from the host, drives `csr_in`/`data_reg_a`/`data_reg_b` until the tile pulses `csr_in_re`, then waits for `csr_out_we`. Each `csr_out`/`data_reg_c` response is queued in a small result FIFO for the host. Sits between the caravel-side host logic and each tile wrapper.

## Interface
- `REG_WIDTH`, 32, width of data registers a/b/c
- `CSR_IN_WIDTH`, 16, width of command CSR driven to tile
- `CSR_OUT_WIDTH`, 16, width of status CSR returned by tile
- `FIFO_DEPTH`, 4, result FIFO entries (power of two, ≥2)
- `TIMEOUT_CYCLES`, 1023, watchdog limit (used only with macro)

Ports:
- `clk` in 1: single clock, rising edge
- `arst_n` in 1: reset, **synchronous, active-low** (sampled on `clk` rising edge only)
- `host_wr` in 1: command strobe, accepted only when `host_ready`=1
- `host_csr` in CSR_IN_WIDTH: command CSR value
- `host_a`, `host_b` in REG_WIDTH: operands
- `host_ready` out 1: FSM in IDLE and FIFO not full
- `res_valid` out 1: FIFO non-empty
- `res_csr` out CSR_OUT_WIDTH, `res_c` out REG_WIDTH: FIFO head (first-word fall-through)
- `res_rd` in 1: pop head; ignored when empty
- `clr_flags` in 1: clears sticky flags
- `ovf_flag` out 1: sticky, response dropped because FIFO full
- `timeout_flag` out 1: sticky, watchdog expired
- `harness_en` out 1: high while a transaction is outstanding
- `csr_in` out CSR_IN_WIDTH, `data_reg_a`/`data_reg_b` out REG_WIDTH: to tile
- `csr_in_re` in 1: tile consumed `csr_in`
- `csr_out` in CSR_OUT_WIDTH, `data_reg_c` in REG_WIDTH, `csr_out_we` in 1: tile response

## Operation
- Reset: FSM=IDLE; `csr_in`, `data_reg_a`, `data_reg_b`=0; `harness_en`=0; FIFO empty (`res_valid`=0, `res_csr`/`res_c`=0); both flags=0; `host_ready`=1.
- **IDLE**: `host_wr`&&`host_ready` → latch host values onto tile outputs, `harness_en`=1 → ISSUE. `host_wr` while not ready: dropped silently.
- **ISSUE**: hold outputs stable. On `csr_in_re`=1, clear `csr_in`/`data_reg_a`/`data_reg_b` to 0 and go to WAIT_RESP.
  - If `csr_out_we` is also high in the same cycle, go straight to IDLE and drop `harness_en`.
- **WAIT_RESP**: on `csr_out_we` → IDLE, `harness_en`=0.
- Response capture is independent of state: every `csr_out_we`=1 cycle pushes {`csr_out`,`data_reg_c`}. Unsolicited responses are also queued.
- FIFO full and push without a simultaneous pop: entry dropped, `ovf_flag` set. Push+pop when full: both happen, no overflow.
- `clr_flags` clears both flags. A set event in the same cycle wins.
- Reset mid-transaction: all state returns to reset values next edge; no response is queued.

## Timing
- `host_wr` sampled at edge k → tile outputs and `harness_en` valid from k (registered), `host_ready`=0 from k.
- `csr_in_re` sampled at edge m → `csr_in`=0 after edge m.
- `csr_out_we` sampled at edge n → entry visible at FIFO head after n if FIFO was empty; `host_ready`=1 after n (unless FIFO now full).
- `res_rd` at edge p → next entry (or `res_valid`=0) after p.
- Minimum issue-to-ready round trip: 2 cycles.

## Configuration
- `TILE_HARNESS_TIMEOUT_EN` defined:
  - Cycle counter runs in ISSUE/WAIT_RESP and resets on entry to ISSUE.
  - At the TIMEOUT_CYCLES-th cycle without completion: FSM → IDLE, tile outputs cleared, `harness_en`=0, `timeout_flag` set.
  - A late `csr_out_we` is still queued.
- Not defined: no counter, FSM waits indefinitely, `timeout_flag` tied 0.

## Test plan
- Reset then `host_wr` csr=0x0001, a=5, b=7; tile pulses `csr_in_re` 3 cycles later and `csr_out_we` (csr_out=0x8000, c=12) 2 cycles after that → `csr_in`=0 after re; `res_valid`=1 with 0x8000/12; `host_ready`=1.
- `csr_in_re` and `csr_out_we` in the same cycle as the first presentation cycle → direct ISSUE→IDLE; one FIFO entry.
- 5 unsolicited `csr_out_we` pulses, no pops, FIFO_DEPTH=4 → 4 entries in order, `ovf_flag`=1, `host_ready`=0; one pop → `host_ready`=1; `clr_flags` → `ovf_flag`=0.
- Push+pop on full FIFO in the same cycle → count stays 4, no overflow, order preserved.
- `arst_n`=0 for 1 cycle while in WAIT_RESP → all outputs at reset values next cycle; a subsequent `csr_out_we` queues normally.
- With `TILE_HARNESS_TIMEOUT_EN`, TIMEOUT_CYCLES=8, tile never asserts `csr_in_re` → after 8 cycles: `timeout_flag`=1, `csr_in`=0, `host_ready`=1.
